// File: rtl/div_signed_frontend.sv
// rtl/div_signed_frontend.sv - signed/unsigned sequencing front/back end for the restoring-division core
module div_signed_frontend #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             timeout,
  output logic             core_rst,
  output logic             core_run,
  output logic [WIDTH-1:0] core_dividend,
  output logic [WIDTH-1:0] core_divisor,
  input  logic             core_ready,
  input  logic [WIDTH-1:0] core_quotient,
  input  logic [WIDTH-1:0] core_remainder
);

  localparam int         MSB = WIDTH - 1;
  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_FIX,
    S_ZERO,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] orig_dividend_q, orig_dividend_d;
  logic [WIDTH-1:0] core_dividend_q, core_dividend_d;
  logic [WIDTH-1:0] core_divisor_q, core_divisor_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             tmo_q, tmo_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             rst_hold_q, rst_hold_d;

  // Operand magnitudes: negation wraps, so -2^(WIDTH-1) maps onto itself.
  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [7:0]       cnt_inc;

  assign dvd_neg = signed_op & dividend[MSB];
  assign dvs_neg = signed_op & divisor[MSB];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dvs_mag = dvs_neg ? -divisor : divisor;
  assign cnt_inc = cnt_q + 8'd1;

  // Next-state and datapath register updates for the sequencing FSM.
  always_comb begin
    state_d         = state_q;
    neg_quo_d       = neg_quo_q;
    neg_rem_d       = neg_rem_q;
    orig_dividend_d = orig_dividend_q;
    core_dividend_d = core_dividend_q;
    core_divisor_d  = core_divisor_q;
    quotient_d      = quotient_q;
    remainder_d     = remainder_q;
    dbz_d           = dbz_q;
    tmo_d           = tmo_q;
    cnt_d           = cnt_q;
    rst_hold_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          neg_quo_d       = signed_op & (dividend[MSB] ^ divisor[MSB]);
          neg_rem_d       = dvd_neg;
          orig_dividend_d = dividend;
          dbz_d           = 1'b0;
          tmo_d           = 1'b0;
          cnt_d           = 8'd0;
          if (divisor == '0) begin
            // The core is never started, so its operand registers stay as they were.
            state_d = S_ZERO;
          end else begin
            core_dividend_d = dvd_mag;
            core_divisor_d  = dvs_mag;
            state_d         = S_CLR;
          end
        end
      end
      S_CLR: begin
        cnt_d   = 8'd0;
        state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        if (core_ready) begin
          state_d = S_FIX;
        end else if (cnt_inc == TMO) begin
          tmo_d       = 1'b1;
          quotient_d  = '0;
          remainder_d = '0;
          state_d     = S_DONE;
        end
      end
      S_FIX: begin
        quotient_d  = neg_quo_q ? -core_quotient : core_quotient;
        remainder_d = neg_rem_q ? -core_remainder : core_remainder;
        state_d     = S_DONE;
      end
      S_ZERO: begin
        quotient_d  = '1;
        remainder_d = orig_dividend_q;
        dbz_d       = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; rst_hold_q keeps core_rst high for one cycle after rst drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      neg_quo_q       <= 1'b0;
      neg_rem_q       <= 1'b0;
      orig_dividend_q <= '0;
      core_dividend_q <= '0;
      core_divisor_q  <= '0;
      quotient_q      <= '0;
      remainder_q     <= '0;
      dbz_q           <= 1'b0;
      tmo_q           <= 1'b0;
      cnt_q           <= 8'd0;
      rst_hold_q      <= 1'b1;
    end else begin
      state_q         <= state_d;
      neg_quo_q       <= neg_quo_d;
      neg_rem_q       <= neg_rem_d;
      orig_dividend_q <= orig_dividend_d;
      core_dividend_q <= core_dividend_d;
      core_divisor_q  <= core_divisor_d;
      quotient_q      <= quotient_d;
      remainder_q     <= remainder_d;
      dbz_q           <= dbz_d;
      tmo_q           <= tmo_d;
      cnt_q           <= cnt_d;
      rst_hold_q      <= rst_hold_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign core_rst      = rst_hold_q | (state_q == S_CLR);
  assign core_run      = (state_q == S_RUN);
  assign core_dividend = core_dividend_q;
  assign core_divisor  = core_divisor_q;
  assign quotient      = quotient_q;
  assign remainder     = remainder_q;
  assign div_by_zero   = dbz_q;
  assign timeout       = tmo_q;

endmodule

// File: tb/tb_div_signed_frontend.sv
// tb/tb_div_signed_frontend.sv - directed bench for div_signed_frontend with a behavioural core
module tb_div_signed_frontend;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero, timeout, core_rst, core_run;
  logic [31:0] quotient, remainder, core_dividend, core_divisor;
  logic        core_ready = 1'b0;
  logic [31:0] core_quotient = '0;
  logic [31:0] core_remainder = '0;

  int n_cmp = 0;
  int n_err = 0;

  // Core model controls
  int  core_lat = 10;
  bit  never_ready = 1'b0;
  int  run_cnt = 0;

  // Per-operation observations
  int          cyc;
  bit          saw_rst, saw_run;
  logic        c1_busy, c1_rst;
  logic [31:0] c1_dd, c1_dv;

  div_signed_frontend #(.WIDTH(32), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
    .timeout(timeout), .core_rst(core_rst), .core_run(core_run),
    .core_dividend(core_dividend), .core_divisor(core_divisor),
    .core_ready(core_ready), .core_quotient(core_quotient),
    .core_remainder(core_remainder)
  );

  always #5 clk = ~clk;

  // Unsigned core model: ready core_lat run cycles after run rises, held until core_rst.
  always @(negedge clk) begin
    if (core_rst) begin
      core_ready = 1'b0;
      run_cnt    = 0;
    end else if (core_run && !core_ready && !never_ready) begin
      run_cnt = run_cnt + 1;
      if (run_cnt == core_lat) begin
        core_ready     = 1'b1;
        core_quotient  = core_dividend / core_divisor;
        core_remainder = core_dividend % core_divisor;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the done cycle.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input bit repulse);
    start = 1'b1; signed_op = sgn; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    saw_rst = core_rst; saw_run = core_run;
    c1_busy = busy; c1_rst = core_rst; c1_dd = core_dividend; c1_dv = core_divisor;
    while (!done && cyc < 400) begin
      if (repulse && cyc == 3) begin
        start = 1'b1; signed_op = 1'b0; dividend = 32'd7; divisor = 32'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
      saw_rst |= core_rst;
      saw_run |= core_run;
    end
    start = 1'b0;
    check1("done_seen", done, 1'b1);
  endtask

  task automatic check_after_done();
    @(negedge clk);
    check1("busy_after_done", busy, 1'b0);
    check1("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    // Reset state
    #12;
    check1("rst_core_rst", core_rst, 1'b1);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_core_run", core_run, 1'b0);
    check("rst_quotient", quotient, 32'h0);
    check("rst_core_dividend", core_dividend, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    check1("rst_hold_core_rst", core_rst, 1'b1);
    @(negedge clk);
    check1("idle_core_rst", core_rst, 1'b0);

    // Unsigned 100 / 7
    run_op(1'b0, 32'd100, 32'd7, 1'b0);
    check1("u_c1_busy", c1_busy, 1'b1);
    check1("u_c1_core_rst", c1_rst, 1'b1);
    check("u_core_dividend", c1_dd, 32'd100);
    check("u_core_divisor", c1_dv, 32'd7);
    check("u_done_cycle", cyc, 32'd13);
    check("u_quotient", quotient, 32'd14);
    check("u_remainder", remainder, 32'd2);
    check1("u_dbz", div_by_zero, 1'b0);
    check1("u_timeout", timeout, 1'b0);
    check_after_done();

    // Signed -100 / 7
    run_op(1'b1, 32'hFFFFFF9C, 32'd7, 1'b0);
    check("sn_core_dividend", c1_dd, 32'd100);
    check("sn_core_divisor", c1_dv, 32'd7);
    check("sn_quotient", quotient, 32'hFFFFFFF2);
    check("sn_remainder", remainder, 32'hFFFFFFFE);
    check_after_done();

    // Signed 100 / -7
    run_op(1'b1, 32'd100, 32'hFFFFFFF9, 1'b0);
    check("sd_core_divisor", c1_dv, 32'd7);
    check("sd_quotient", quotient, 32'hFFFFFFF2);
    check("sd_remainder", remainder, 32'd2);
    check_after_done();

    // Divide by zero, signed dividend -5
    run_op(1'b1, 32'hFFFFFFFB, 32'd0, 1'b0);
    check("z_done_cycle", cyc, 32'd2);
    check1("z_no_core_rst", saw_rst, 1'b0);
    check1("z_no_core_run", saw_run, 1'b0);
    check("z_core_dividend_untouched", core_dividend, 32'd100);
    check("z_quotient", quotient, 32'hFFFFFFFF);
    check("z_remainder", remainder, 32'hFFFFFFFB);
    check1("z_dbz", div_by_zero, 1'b1);
    check_after_done();

    // Most-negative / -1 with start re-pulsed while busy
    core_lat = 3;
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    check("mn_core_dividend", c1_dd, 32'h80000000);
    check("mn_core_divisor", c1_dv, 32'd1);
    check("mn_quotient", quotient, 32'h80000000);
    check("mn_remainder", remainder, 32'h0);
    check1("mn_dbz", div_by_zero, 1'b0);
    check_after_done();
    repeat (3) @(negedge clk);
    check1("mn_no_queued_op", busy, 1'b0);
    check("mn_quotient_held", quotient, 32'h80000000);
    core_lat = 10;

    // Core never ready: timeout
    never_ready = 1'b1;
    run_op(1'b0, 32'd55, 32'd5, 1'b0);
    check("t_done_cycle", cyc, 32'd257);
    check1("t_timeout", timeout, 1'b1);
    check("t_quotient", quotient, 32'h0);
    check("t_remainder", remainder, 32'h0);
    check_after_done();
    never_ready = 1'b0;

    // Recovery after timeout
    run_op(1'b0, 32'd50, 32'd5, 1'b0);
    check1("tr_timeout", timeout, 1'b0);
    check("tr_quotient", quotient, 32'd10);
    check("tr_remainder", remainder, 32'd0);
    check_after_done();

    // Reset asserted mid-RUN
    start = 1'b1; signed_op = 1'b0; dividend = 32'd1000; divisor = 32'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check1("mr_in_run", core_run, 1'b1);
    #2 rst = 1'b1;
    #1;
    check1("mr_busy", busy, 1'b0);
    check1("mr_core_run", core_run, 1'b0);
    check1("mr_core_rst", core_rst, 1'b1);
    check1("mr_done", done, 1'b0);
    check("mr_quotient", quotient, 32'h0);
    check("mr_core_dividend", core_dividend, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    check1("mr_hold_core_rst", core_rst, 1'b1);
    @(negedge clk);
    check1("mr_idle_core_rst", core_rst, 1'b0);

    run_op(1'b0, 32'd9, 32'd3, 1'b0);
    check("pr_quotient", quotient, 32'd3);
    check("pr_remainder", remainder, 32'd0);
    check_after_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_signed_frontend.md
# div_signed_frontend

Sequencing front/back end for the 32-bit restoring-division unit. It accepts signed or unsigned operands through a start/done handshake and converts them to magnitudes. It re-arms the division controller with a reset pulse, drives its run input and waits for its ready. It then applies sign correction to the quotient and remainder and returns them with divide-by-zero and timeout flags. It sits directly upstream and downstream of the division controller/datapath, which only handles unsigned magnitudes and returns to idle only through reset.

## Interface
Parameters:
- WIDTH, 32, operand/result width
- TIMEOUT, 255, max cycles to wait for core_ready before abort (8-bit counter)

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- signed_op  in  1  1 = signed (two's complement) division, 0 = unsigned
- dividend  in  WIDTH  dividend, sampled with start
- divisor  in  WIDTH  divisor, sampled with start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; results valid from this cycle
- quotient  out  WIDTH  final quotient, held until the next accepted start
- remainder  out  WIDTH  final remainder, held likewise
- div_by_zero  out  1  set with done when divisor == 0
- timeout  out  1  set with done when the core failed to report ready
- core_rst  out  1  reset to the division controller
- core_run  out  1  run to the division controller
- core_dividend  out  WIDTH  registered dividend magnitude
- core_divisor  out  WIDTH  registered divisor magnitude
- core_ready  in  1  controller ready, held until core_rst
- core_quotient  in  WIDTH  unsigned quotient from core
- core_remainder  in  WIDTH  unsigned remainder from core

## Operation
- Reset values: core_rst=1, all other outputs 0, state IDLE, timeout counter 0.
- IDLE: core_rst=0, core_run=0. On start=1:
  - Latch sign_q = signed_op & (dividend[MSB] ^ divisor[MSB]).
  - Latch sign_r = signed_op & dividend[MSB].
  - core_dividend <= (signed_op & dividend[MSB]) ? -dividend : dividend; core_divisor likewise.
  - Clear div_by_zero and timeout.
  - Go to ZERO if divisor==0, else CLR.
- CLR: core_rst=1 for exactly one cycle; go to RUN.
- RUN: core_run=1 held; counter increments each cycle.
  - On core_ready=1: core_run=0, go to FIX.
  - On counter==TIMEOUT with no ready: set timeout, quotient=0, remainder=0, go to DONE.
- FIX:
  - quotient <= sign_q ? -core_quotient : core_quotient.
  - remainder <= sign_r ? -core_remainder : core_remainder.
  - Go to DONE.
- ZERO: quotient <= all ones, remainder <= original dividend (unmodified), div_by_zero=1; go to DONE. The core is not started.
- DONE: done=1 for one cycle; busy=0 from the next cycle; go to IDLE. The core is left in its ready state until the next CLR.
- Negation is WIDTH-bit two's complement, wrap-around. Signed -2^(WIDTH-1) / -1 therefore yields quotient 0x80000000, remainder 0, with no flag.
- start outside IDLE is ignored and has no queueing. start during DONE is also ignored.
- rst at any time: immediate return to reset values. core_rst=1 while rst is high and for the first cycle after, then 0 in IDLE.

## Timing
- Edge E0 samples start=1. busy=1 and CLR (core_rst=1) during cycle 1. RUN (core_run=1) from cycle 2.
- core_ready sampled high at edge En: FIX during cycle n+1, done=1 during cycle n+2.
- Added latency over the core is 4 cycles: accept, CLR, FIX, DONE.
- Divide-by-zero: done in cycle 2 after E0, core signals untouched.
- core_dividend/core_divisor are stable from cycle 1 until the next accepted start.

## Test plan
- Unsigned 100/7, core model ready 10 cycles after run: core sees 100,7; done → q=14, r=2, busy low the following cycle.
- Signed -100/7 (0xFFFFFF9C, 7): core sees 100,7; done → q=0xFFFFFFF2 (-14), r=0xFFFFFFFE (-2). Then 100/-7 → q=-14, r=2.
- Divisor 0, signed dividend -5: no core_rst/core_run pulse; done 2 cycles after start; q=0xFFFFFFFF, r=0xFFFFFFFB, div_by_zero=1.
- Signed 0x80000000/0xFFFFFFFF: q=0x80000000, r=0. Also start re-pulsed while busy: ignored, results unchanged.
- Core model never asserts ready: done exactly TIMEOUT cycles into RUN with timeout=1, q=r=0. Next start completes normally with timeout=0.
- rst asserted mid-RUN: all outputs 0 immediately, core_rst=1. After release, a new 9/3 request gives q=3, r=0.
